// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: step sequencer and decoder for the 5-step multicycle CPU datapath.
// Drives datapath enables and mux selects from the instruction in iIR. It also handles
// memory wait states, beq/bne/br, early retirement of branches and stw, and illegal-opcode detection.
// Optional feature: define CTRL_MEM_TIMEOUT_EN to abort memory stalls after TIMEOUT_CYCLES
// stalled cycles and raise the sticky oFault flag.
module multicycle_ctrl #(
  parameter int EARLY_RETIRE   = 1,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [31:0] iIR,
  input  logic        iMemReady,
  input  logic        iALUZero,
  output logic [4:0]  oStep,
  output logic        oIREn,
  output logic        oPCEn,
  output logic        oPCTempEn,
  output logic        oRFWrite,
  output logic        oBSel,
  output logic        oINCSel,
  output logic        oMASel,
  output logic        oPCSel,
  output logic [1:0]  oCSel,
  output logic [1:0]  oYSel,
  output logic [3:0]  oALUOp,
  output logic        oMemRead,
  output logic        oMemWrite,
  output logic        oRetire,
  output logic        oIllegal,
  output logic        oFault
);

  typedef enum logic [2:0] {T1, T2, T3, T4, T5} step_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  step_t r_step;
  step_t w_nextStep;

  logic [5:0]  w_opcode;
  logic [10:0] w_opx;
  logic w_isAddi, w_isBr, w_isBne, w_isBeq, w_isStw, w_isLdw;
  logic w_isRtype, w_isAdd, w_isSub, w_isLegal, w_isBranch, w_isMem;
  logic w_takeBranch, w_memReq, w_stall, w_expire;
  logic w_unusedIr;

  assign w_opcode  = iIR[5:0];
  assign w_opx     = iIR[16:6];
  assign w_isAddi  = (w_opcode == 6'h04);
  assign w_isBr    = (w_opcode == 6'h06);
  assign w_isBne   = (w_opcode == 6'h1E);
  assign w_isBeq   = (w_opcode == 6'h26);
  assign w_isStw   = (w_opcode == 6'h15);
  assign w_isLdw   = (w_opcode == 6'h17);
  assign w_isRtype = (w_opcode == 6'h3A);
  assign w_isAdd   = w_isRtype && (w_opx == 11'h031);
  assign w_isSub   = w_isRtype && (w_opx == 11'h039);
  assign w_isLegal = w_isAddi | w_isBr | w_isBne | w_isBeq | w_isStw | w_isLdw | w_isAdd | w_isSub;
  assign w_isBranch = w_isBr | w_isBne | w_isBeq;
  assign w_isMem    = w_isLdw | w_isStw;
  assign w_takeBranch = w_isBr | (w_isBeq & iALUZero) | (w_isBne & ~iALUZero);

  // Upper immediate bits are consumed by the datapath, not by the controller.
  assign w_unusedIr = ^iIR[31:17];

  // Memory is only requested during fetch and during the T4 of loads and stores.
  assign w_memReq = (r_step == T1) || ((r_step == T4) && w_isMem);
  assign w_stall  = w_memReq && !iMemReady;

`ifdef CTRL_MEM_TIMEOUT_EN
  logic [7:0] r_waitCnt;
  logic       r_fault;

  // A stall that reaches the limit is abandoned in that same cycle; a late ready still wins.
  assign w_expire = w_stall && (r_waitCnt == 8'(TIMEOUT_CYCLES - 1));
  assign oFault   = r_fault;

  // Count consecutive stalled cycles and latch the sticky fault on expiry.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_waitCnt <= 8'd0;
      r_fault   <= 1'b0;
    end else begin
      if (w_expire) r_fault <= 1'b1;
      if (w_expire || !w_stall || (w_nextStep != r_step)) r_waitCnt <= 8'd0;
      else r_waitCnt <= r_waitCnt + 8'd1;
    end
  end
`else
  logic [7:0] w_unusedTimeout;

  assign w_unusedTimeout = 8'(TIMEOUT_CYCLES);
  assign w_expire = 1'b0;
  assign oFault   = 1'b0;
`endif

  // Step register; reset returns to fetch and discards any instruction in flight.
  always_ff @(posedge iClk) begin
    if (iRst) r_step <= T1;
    else r_step <= w_nextStep;
  end

  // Next-step selection and per-step datapath controls.
  always_comb begin
    w_nextStep = r_step;
    oStep      = 5'b00001 << r_step;
    oIREn      = 1'b0;
    oPCEn      = 1'b0;
    oPCTempEn  = 1'b0;
    oRFWrite   = 1'b0;
    oBSel      = 1'b0;
    oINCSel    = 1'b0;
    oMASel     = 1'b0;
    oPCSel     = 1'b1;
    oCSel      = 2'b00;
    oYSel      = 2'b00;
    oALUOp     = ALU_ADD;
    oMemRead   = 1'b0;
    oMemWrite  = 1'b0;
    oRetire    = 1'b0;
    oIllegal   = 1'b0;

    case (r_step)
      T1: begin
        oMemRead = 1'b1;
        oMASel   = 1'b1;
        if (iMemReady) begin
          oIREn      = 1'b1;
          oPCEn      = 1'b1;
          w_nextStep = T2;
        end
      end
      T2: begin
        if (!w_isLegal) begin
          oIllegal   = 1'b1;
          oRetire    = 1'b1;
          w_nextStep = T1;
        end else begin
          w_nextStep = T3;
        end
      end
      T3: begin
        oPCTempEn = 1'b1;
        if (w_isAddi || w_isLdw || w_isStw) begin
          oBSel = 1'b1;
        end else if (w_isSub || w_isBeq || w_isBne) begin
          oALUOp = ALU_SUB;
        end
        if (w_isBranch && w_takeBranch) begin
          oINCSel = 1'b1;
          oPCEn   = 1'b1;
        end
        if (w_isBranch && (EARLY_RETIRE != 0)) begin
          oRetire    = 1'b1;
          w_nextStep = T1;
        end else begin
          w_nextStep = T4;
        end
      end
      T4: begin
        if (w_isLdw) begin
          oMemRead = 1'b1;
          oYSel    = 2'b01;
        end
        if (w_isStw) oMemWrite = 1'b1;
        if (!w_isMem) begin
          w_nextStep = T5;
        end else if (iMemReady) begin
          if (w_isStw && (EARLY_RETIRE != 0)) begin
            oRetire    = 1'b1;
            w_nextStep = T1;
          end else begin
            w_nextStep = T5;
          end
        end
      end
      T5: begin
        oRFWrite   = w_isAdd | w_isSub | w_isAddi | w_isLdw;
        oCSel      = w_isRtype ? 2'b01 : 2'b00;
        oRetire    = 1'b1;
        w_nextStep = T1;
      end
      default: w_nextStep = T1;
    endcase

    if (w_expire) begin
      oMemRead   = 1'b0;
      oMemWrite  = 1'b0;
      oIREn      = 1'b0;
      oPCEn      = 1'b0;
      oRFWrite   = 1'b0;
      oRetire    = 1'b0;
      w_nextStep = T1;
    end

    if (iRst) begin
      w_nextStep = T1;
      oStep      = 5'b00001;
      oIREn      = 1'b0;
      oPCEn      = 1'b0;
      oPCTempEn  = 1'b0;
      oRFWrite   = 1'b0;
      oBSel      = 1'b0;
      oINCSel    = 1'b0;
      oMASel     = 1'b0;
      oPCSel     = 1'b0;
      oCSel      = 2'b00;
      oYSel      = 2'b00;
      oALUOp     = ALU_ADD;
      oMemRead   = 1'b0;
      oMemWrite  = 1'b0;
      oRetire    = 1'b0;
      oIllegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed vector table plus hand sequences for latency and memory timeout.
module tb_multicycle_ctrl;

  localparam logic [31:0] ADDI  = 32'h0FA00004;
  localparam logic [31:0] ADD   = 32'h00000C7A;
  localparam logic [31:0] SUB   = 32'h00000E7A;
  localparam logic [31:0] BEQ   = 32'h00000026;
  localparam logic [31:0] BNE   = 32'h0000001E;
  localparam logic [31:0] BR    = 32'h00000006;
  localparam logic [31:0] STW   = 32'h00000015;
  localparam logic [31:0] LDW   = 32'h00000017;
  localparam logic [31:0] ILL   = 32'h0000003F;
  localparam logic [31:0] BADRT = 32'h0000003A;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic [31:0] iIR = ADDI;
  logic        iMemReady = 1'b1;
  logic        iALUZero = 1'b0;
  logic [4:0]  oStep;
  logic        oIREn, oPCEn, oPCTempEn, oRFWrite;
  logic        oBSel, oINCSel, oMASel, oPCSel;
  logic [1:0]  oCSel, oYSel;
  logic [3:0]  oALUOp;
  logic        oMemRead, oMemWrite, oRetire, oIllegal, oFault;

  int nCompared = 0;
  int nMismatched = 0;

  // en = {IREn,PCEn,PCTempEn,RFWrite}; sel = {BSel,INCSel,MASel,PCSel};
  // flg = {MemRead,MemWrite,Retire,Illegal,Fault}
  typedef struct {
    logic        rst;
    logic [31:0] ir;
    logic        rdy;
    logic        z;
    logic [4:0]  step;
    logic [3:0]  en;
    logic [3:0]  sel;
    logic [1:0]  cSel;
    logic [1:0]  ySel;
    logic [3:0]  alu;
    logic [4:0]  flg;
  } vec_t;

  vec_t vecs[$];

  multicycle_ctrl #(.EARLY_RETIRE(1), .TIMEOUT_CYCLES(4)) dut (
    .iClk(iClk), .iRst(iRst), .iIR(iIR), .iMemReady(iMemReady), .iALUZero(iALUZero),
    .oStep(oStep), .oIREn(oIREn), .oPCEn(oPCEn), .oPCTempEn(oPCTempEn), .oRFWrite(oRFWrite),
    .oBSel(oBSel), .oINCSel(oINCSel), .oMASel(oMASel), .oPCSel(oPCSel),
    .oCSel(oCSel), .oYSel(oYSel), .oALUOp(oALUOp),
    .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oRetire(oRetire), .oIllegal(oIllegal),
    .oFault(oFault)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 iClk = ~iClk;

  // Drive inputs just after the falling edge, then let combinational outputs settle.
  task automatic applyStimulus(input logic rst, input logic [31:0] ir, input logic rdy, input logic z);
    @(negedge iClk);
    iRst = rst;
    iIR = ir;
    iMemReady = rdy;
    iALUZero = z;
    #1;
  endtask

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Run one instruction from T1, inserting T4 wait states, and count cycles up to retire.
  task automatic measureLatency(input string name, input logic [31:0] ir, input logic z,
                                input int waits, input int expCycles);
    int cycles = 0;
    int waitsLeft = waits;
    for (int c = 1; c <= 30; c++) begin
      @(negedge iClk);
      iRst = 1'b0;
      iIR = ir;
      iALUZero = z;
      if (oStep == 5'b01000 && waitsLeft > 0) begin
        iMemReady = 1'b0;
        waitsLeft--;
      end else begin
        iMemReady = 1'b1;
      end
      #1;
      if (oRetire) begin
        cycles = c;
        break;
      end
    end
    checkOutput(name, cycles, expCycles);
  endtask

  function automatic logic [9:0] memView();
    return {oStep, oMemRead, oIREn, oPCEn, oRetire, oFault};
  endfunction

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [24:0] act, exp;

    // Reset
    vecs.push_back('{1, ADDI, 1, 0, 5'b00001, 4'b0000, 4'b0000, 2'b00, 2'b00, 4'b0000, 5'b00000});
    vecs.push_back('{1, ADDI, 1, 0, 5'b00001, 4'b0000, 4'b0000, 2'b00, 2'b00, 4'b0000, 5'b00000});
    // addi, zero wait
    vecs.push_back('{0, ADDI, 1, 0, 5'b00001, 4'b1100, 4'b0011, 2'b00, 2'b00, 4'b0000, 5'b10000});
    vecs.push_back('{0, ADDI, 1, 0, 5'b00010, 4'b0000, 4'b0001, 2'b00, 2'b00, 4'b0000, 5'b00000});
    vecs.push_back('{0, ADDI, 1, 0, 5'b00100, 4'b0010, 4'b1001, 2'b00, 2'b00, 4'b0000, 5'b00000});
    vecs.push_back('{0, ADDI, 1, 0, 5'b01000, 4'b0000, 4'b0001, 2'b00, 2'b00, 4'b0000, 5'b00000});
    vecs.push_back('{0, ADDI, 1, 0, 5'b10000, 4'b0001, 4'b0001, 2'b00, 2'b00, 4'b0000, 5'b00100});
    // add with two fetch wait states
    vecs.push_back('{0, ADD, 0, 0, 5'b00001, 4'b0000, 4'b0011, 2'b00, 2'b00, 4'b0000, 5'b10000});
    vecs.push_back('{0, ADD, 0, 0, 5'b00001, 4'b0000, 4'b0011, 2'b00, 2'b00, 4'b0000, 5'b10000});
    vecs.push_back('{0, ADD, 1, 0, 5'b00001, 4'b1100, 4'b0011, 2'b00, 2'b00, 4'b0000, 5'b10000});
    vecs.push_back('{0, ADD, 1, 0, 5'b00010, 4'b0000, 4'b0001, 2'b00, 2'b00, 4'b0000, 5'b00000});
    vecs.push_back('{0, ADD, 1, 0, 5'b00100, 4'b0010, 4'b0001, 2'b00, 2'b00, 4'b0000, 5'b00000});
    vecs.push_back('{0, ADD, 1, 0, 5'b01000, 4'b0000, 4'b0001, 2'b00, 2'b00, 4'b0000, 5'b00000});
    vecs.push_back('{0, ADD, 1, 0, 5'b10000, 4'b0001, 4'b0001, 2'b01, 2'b00, 4'b0000, 5'b00100});
    // sub; iMemReady low outside memory steps must be ignored
    vecs.push_back('{0, SUB, 1, 0, 5'b00001, 4'b1100, 4'b0011, 2'b00, 2'b00, 4'b0000, 5'b10000});
    vecs.push_back('{0, SUB, 0, 0, 5'b00010, 4'b0000, 4'b0001, 2'b00, 2'b00, 4'b0000, 5'b00000});
    vecs.push_back('{0, SUB, 0, 0, 5'b00100, 4'b0010, 4'b0001, 2'b00, 2'b00, 4'b0001, 5'b00000});
    vecs.push_back('{0, SUB, 0, 0, 5'b01000, 4'b0000, 4'b0001, 2'b00, 2'b00, 4'b0000, 5'b00000});
    vecs.push_back('{0, SUB, 0, 0, 5'b10000, 4'b0001, 4'b0001, 2'b01, 2'b00, 4'b0000, 5'b00100});
    // beq taken
    vecs.push_back('{0, BEQ, 1, 1, 5'b00001, 4'b1100, 4'b0011, 2'b00, 2'b00, 4'b0000, 5'b10000});
    vecs.push_back('{0, BEQ, 1, 1, 5'b00010, 4'b0000, 4'b0001, 2'b00, 2'b00, 4'b0000, 5'b00000});
    vecs.push_back('{0, BEQ, 1, 1, 5'b00100, 4'b0110, 4'b0101, 2'b00, 2'b00, 4'b0001, 5'b00100});
    // beq not taken
    vecs.push_back('{0, BEQ, 1, 0, 5'b00001, 4'b1100, 4'b0011, 2'b00, 2'b00, 4'b0000, 5'b10000});
    vecs.push_back('{0, BEQ, 1, 0, 5'b00010, 4'b0000, 4'b0001, 2'b00, 2'b00, 4'b0000, 5'b00000});
    vecs.push_back('{0, BEQ, 1, 0, 5'b00100, 4'b0010, 4'b0001, 2'b00, 2'b00, 4'b0001, 5'b00100});
    // bne taken, then bne not taken
    vecs.push_back('{0, BNE, 1, 0, 5'b00001, 4'b1100, 4'b0011, 2'b00, 2'b00, 4'b0000, 5'b10000});
    vecs.push_back('{0, BNE, 1, 0, 5'b00010, 4'b0000, 4'b0001, 2'b00, 2'b00, 4'b0000, 5'b00000});
    vecs.push_back('{0, BNE, 1, 0, 5'b00100, 4'b0110, 4'b0101, 2'b00, 2'b00, 4'b0001, 5'b00100});
    vecs.push_back('{0, BNE, 1, 1, 5'b00001, 4'b1100, 4'b0011, 2'b00, 2'b00, 4'b0000, 5'b10000});
    vecs.push_back('{0, BNE, 1, 1, 5'b00010, 4'b0000, 4'b0001, 2'b00, 2'b00, 4'b0000, 5'b00000});
    vecs.push_back('{0, BNE, 1, 1, 5'b00100, 4'b0010, 4'b0001, 2'b00, 2'b00, 4'b0001, 5'b00100});
    // br always taken, zero flag irrelevant
    vecs.push_back('{0, BR, 1, 1, 5'b00001, 4'b1100, 4'b0011, 2'b00, 2'b00, 4'b0000, 5'b10000});
    vecs.push_back('{0, BR, 1, 1, 5'b00010, 4'b0000, 4'b0001, 2'b00, 2'b00, 4'b0000, 5'b00000});
    vecs.push_back('{0, BR, 1, 1, 5'b00100, 4'b0110, 4'b0101, 2'b00, 2'b00, 4'b0000, 5'b00100});
    // ldw with three T4 wait states
    vecs.push_back('{0, LDW, 1, 0, 5'b00001, 4'b1100, 4'b0011, 2'b00, 2'b00, 4'b0000, 5'b10000});
    vecs.push_back('{0, LDW, 1, 0, 5'b00010, 4'b0000, 4'b0001, 2'b00, 2'b00, 4'b0000, 5'b00000});
    vecs.push_back('{0, LDW, 1, 0, 5'b00100, 4'b0010, 4'b1001, 2'b00, 2'b00, 4'b0000, 5'b00000});
    vecs.push_back('{0, LDW, 0, 0, 5'b01000, 4'b0000, 4'b0001, 2'b00, 2'b01, 4'b0000, 5'b10000});
    vecs.push_back('{0, LDW, 0, 0, 5'b01000, 4'b0000, 4'b0001, 2'b00, 2'b01, 4'b0000, 5'b10000});
    vecs.push_back('{0, LDW, 0, 0, 5'b01000, 4'b0000, 4'b0001, 2'b00, 2'b01, 4'b0000, 5'b10000});
    vecs.push_back('{0, LDW, 1, 0, 5'b01000, 4'b0000, 4'b0001, 2'b00, 2'b01, 4'b0000, 5'b10000});
    vecs.push_back('{0, LDW, 1, 0, 5'b10000, 4'b0001, 4'b0001, 2'b00, 2'b00, 4'b0000, 5'b00100});
    // stw interrupted by a two-cycle reset in a stalled T4
    vecs.push_back('{0, STW, 1, 0, 5'b00001, 4'b1100, 4'b0011, 2'b00, 2'b00, 4'b0000, 5'b10000});
    vecs.push_back('{0, STW, 1, 0, 5'b00010, 4'b0000, 4'b0001, 2'b00, 2'b00, 4'b0000, 5'b00000});
    vecs.push_back('{0, STW, 1, 0, 5'b00100, 4'b0010, 4'b1001, 2'b00, 2'b00, 4'b0000, 5'b00000});
    vecs.push_back('{0, STW, 0, 0, 5'b01000, 4'b0000, 4'b0001, 2'b00, 2'b00, 4'b0000, 5'b01000});
    vecs.push_back('{1, STW, 0, 0, 5'b00001, 4'b0000, 4'b0000, 2'b00, 2'b00, 4'b0000, 5'b00000});
    vecs.push_back('{1, STW, 0, 0, 5'b00001, 4'b0000, 4'b0000, 2'b00, 2'b00, 4'b0000, 5'b00000});
    // stw again, completing with early retirement in T4
    vecs.push_back('{0, STW, 1, 0, 5'b00001, 4'b1100, 4'b0011, 2'b00, 2'b00, 4'b0000, 5'b10000});
    vecs.push_back('{0, STW, 1, 0, 5'b00010, 4'b0000, 4'b0001, 2'b00, 2'b00, 4'b0000, 5'b00000});
    vecs.push_back('{0, STW, 1, 0, 5'b00100, 4'b0010, 4'b1001, 2'b00, 2'b00, 4'b0000, 5'b00000});
    vecs.push_back('{0, STW, 1, 0, 5'b01000, 4'b0000, 4'b0001, 2'b00, 2'b00, 4'b0000, 5'b01100});
    // illegal opcode, then R-type with an undefined OPX
    vecs.push_back('{0, ILL, 1, 0, 5'b00001, 4'b1100, 4'b0011, 2'b00, 2'b00, 4'b0000, 5'b10000});
    vecs.push_back('{0, ILL, 1, 0, 5'b00010, 4'b0000, 4'b0001, 2'b00, 2'b00, 4'b0000, 5'b00110});
    vecs.push_back('{0, BADRT, 1, 0, 5'b00001, 4'b1100, 4'b0011, 2'b00, 2'b00, 4'b0000, 5'b10000});
    vecs.push_back('{0, BADRT, 1, 0, 5'b00010, 4'b0000, 4'b0001, 2'b00, 2'b00, 4'b0000, 5'b00110});

    $display("[TB] applying %0d table vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].ir, vecs[i].rdy, vecs[i].z);
      act = {oStep, oIREn, oPCEn, oPCTempEn, oRFWrite, oBSel, oINCSel, oMASel, oPCSel,
             oCSel, oYSel, oALUOp, oMemRead, oMemWrite, oRetire, oIllegal, oFault};
      exp = {vecs[i].step, vecs[i].en, vecs[i].sel, vecs[i].cSel, vecs[i].ySel,
             vecs[i].alu, vecs[i].flg};
      checkOutput($sformatf("vec[%0d]", i), 32'(act), 32'(exp));
    end

    // Instruction latency from fetch to retire pulse
    measureLatency("latency addi", ADDI, 1'b0, 0, 5);
    measureLatency("latency beq", BEQ, 1'b1, 0, 3);
    measureLatency("latency bne", BNE, 1'b1, 0, 3);
    measureLatency("latency stw 1 wait", STW, 1'b0, 1, 5);
    measureLatency("latency ldw 3 waits", LDW, 1'b0, 3, 8);

`ifdef CTRL_MEM_TIMEOUT_EN
    // Fetch stalls: abort on the fourth stalled cycle, then retry with the fault latched
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b0, ADDI, 1'b0, 1'b0);
      checkOutput($sformatf("timeout stall %0d", k), 32'(memView()), 32'({5'b00001, 5'b10000}));
    end
    applyStimulus(1'b0, ADDI, 1'b0, 1'b0);
    checkOutput("timeout abort", 32'(memView()), 32'({5'b00001, 5'b00000}));
    applyStimulus(1'b0, ADDI, 1'b1, 1'b0);
    checkOutput("timeout retry", 32'(memView()), 32'({5'b00001, 5'b11101}));
    applyStimulus(1'b0, ADDI, 1'b1, 1'b0);
    checkOutput("fault sticky", 32'(memView()), 32'({5'b00010, 5'b00001}));
    applyStimulus(1'b1, ADDI, 1'b1, 1'b0);
    applyStimulus(1'b0, ADDI, 1'b0, 1'b0);
    checkOutput("fault cleared", 32'(memView()), 32'({5'b00001, 5'b10000}));
    applyStimulus(1'b0, ADDI, 1'b0, 1'b0);
    applyStimulus(1'b0, ADDI, 1'b0, 1'b0);
    applyStimulus(1'b0, ADDI, 1'b1, 1'b0);
    checkOutput("ready wins expiry", 32'(memView()), 32'({5'b00001, 5'b11100}));
    applyStimulus(1'b0, ADDI, 1'b1, 1'b0);
    checkOutput("no fault after win", 32'(memView()), 32'({5'b00010, 5'b00000}));
`else
    // Without the timeout, a long fetch stall simply waits
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, ADDI, 1'b0, 1'b0);
      checkOutput($sformatf("long stall %0d", k), 32'(memView()), 32'({5'b00001, 5'b10000}));
    end
    applyStimulus(1'b0, ADDI, 1'b1, 1'b0);
    checkOutput("stall released", 32'(memView()), 32'({5'b00001, 5'b11100}));
    applyStimulus(1'b0, ADDI, 1'b1, 1'b0);
    checkOutput("after stall T2", 32'(memView()), 32'({5'b00010, 5'b00000}));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
